qdi_1of4_sync_responder: RTL and testbench

Clocked responder at the far end of the 1-of-4 four-phase data/control channel pair. It samples a data token and a control token, acknowledges both jointly, and applies the control opcode: drop, forward, forward complemented, or forward twice. Results are buffered in a small FIFO and re-emitted as 1-of-4 tokens on an output channel. It is the synthesizable, single-clock counterpart that a split/merge token source drives, and it feeds a 1-of-4 receiver downstream.

---
 rtl/qdi_1of4_pkg.sv | 44 ++++
 rtl/qdi_sync_bit.sv | 20 ++
 rtl/qdi_1of4_sync_responder.sv | 172 +++++++++++++++++
 tb/tb_qdi_1of4_sync_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/qdi_1of4_pkg.sv
// Shared definitions for the 1-of-4 QDI responder: opcodes, FSM states,
// the FIFO entry layout and 1-of-4 code helpers.
package qdi_1of4_pkg;

   localparam logic [1:0] OP_DROP = 2'd0;
   localparam logic [1:0] OP_INV  = 2'd1;
   localparam logic [1:0] OP_DUP  = 2'd2;
   localparam logic [1:0] OP_FWD  = 2'd3;

   typedef enum logic [1:0] {
      IN_WAIT    = 2'd0,
      IN_ACK     = 2'd1,
      IN_NEUTRAL = 2'd2
   } in_state_e;

   typedef enum logic [1:0] {
      OUT_IDLE  = 2'd0,
      OUT_DRIVE = 2'd1,
      OUT_RTZ   = 2'd2
   } out_state_e;

   typedef struct packed {
      logic       dup;
      logic [1:0] value;
   } fifo_entry_t;

   function automatic logic is_onehot4(input logic [3:0] x);
      return (x != 4'b0000) && ((x & (x - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [1:0] onehot2bin(input logic [3:0] x);
      case (x)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] bin2onehot(input logic [1:0] b);
      return 4'b0001 << b;
   endfunction

endpackage

// File: rtl/qdi_sync_bit.sv
// SYNC_STAGES-deep flop chain with asynchronous active-low clear.
module qdi_sync_bit #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[SYNC_STAGES-2:0], d};
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/qdi_1of4_sync_responder.sv
// Clocked far-end responder for a 1-of-4 data/control channel pair with an output FIFO.
// Define QDI_RESPONDER_ERRCHK_EN to enable the sticky protocol-error checker (ERR).
module qdi_1of4_sync_responder
   import qdi_1of4_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [3:0]               Rx,
   output logic                     Rxe,
   input  logic [3:0]               Cx,
   output logic                     Cxe,
   output logic [3:0]               Tx,
   input  logic                     Txe,
   output logic                     ERR,
   output logic [$clog2(DEPTH):0]   LEVEL
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [3:0] rx_s, cx_s;
   logic       txe_s;

   for (genvar i = 0; i < 4; i++) begin : g_sync
      qdi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
         .clk(CLK), .rst_n(RESET), .d(Rx[i]), .q(rx_s[i]));
      qdi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_cx (
         .clk(CLK), .rst_n(RESET), .d(Cx[i]), .q(cx_s[i]));
   end

   qdi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_txe (
      .clk(CLK), .rst_n(RESET), .d(Txe), .q(txe_s));

   in_state_e   in_st;
   out_state_e  out_st;
   logic        rxe_q;
   logic [3:0]  tx_q;

   fifo_entry_t       mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   fifo_entry_t       head, push_ent;

   logic       rx_v, cx_v, full, blocked;
   logic [1:0] d_val, c_val;
   logic       accept, push, pop, clr_dup;

   assign rx_v  = is_onehot4(rx_s);
   assign cx_v  = is_onehot4(cx_s);
   assign d_val = onehot2bin(rx_s);
   assign c_val = onehot2bin(cx_s);
   assign full  = (count == FULL_CNT);
   assign head  = mem[rd_ptr];

   assign accept = (in_st == IN_WAIT) && rx_v && cx_v && !full && !blocked;
   assign push   = accept && (c_val != OP_DROP);

   always_comb begin
      push_ent       = '0;
      push_ent.dup   = (c_val == OP_DUP);
      push_ent.value = (c_val == OP_INV) ? ~d_val : d_val;
   end

   // A dup entry is replayed by clearing its flag in place instead of popping.
   assign pop     = (out_st == OUT_RTZ) && txe_s && !head.dup;
   assign clr_dup = (out_st == OUT_RTZ) && txe_s &&  head.dup;

`ifdef QDI_RESPONDER_ERRCHK_EN
   logic [3:0] rx_p, cx_p;
   logic       blk_q, err_q, err_evt, rx_multi, cx_multi, rx_swap, cx_swap;

   assign rx_multi = (rx_s != 4'b0000) && !rx_v;
   assign cx_multi = (cx_s != 4'b0000) && !cx_v;
   assign rx_swap  = is_onehot4(rx_p) && rx_v && (rx_s != rx_p);
   assign cx_swap  = is_onehot4(cx_p) && cx_v && (cx_s != cx_p);
   assign err_evt  = rx_multi || cx_multi ||
                     ((in_st == IN_WAIT) && (rx_swap || cx_swap));
   // The offending token stays ignored until both channels return neutral.
   assign blocked  = blk_q || err_evt;
   assign ERR      = err_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rx_p  <= '0;
         cx_p  <= '0;
         blk_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         rx_p <= rx_s;
         cx_p <= cx_s;
         if (err_evt) err_q <= 1'b1;
         if (err_evt)                                    blk_q <= 1'b1;
         else if ((rx_s == 4'b0000) && (cx_s == 4'b0000)) blk_q <= 1'b0;
      end
   end
`else
   assign blocked = 1'b0;
   assign ERR     = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         in_st <= IN_WAIT;
         rxe_q <= 1'b1;
      end else begin
         case (in_st)
            IN_WAIT: if (accept) begin
               in_st <= IN_ACK;
               rxe_q <= 1'b0;
            end
            IN_ACK: if ((rx_s == 4'b0000) && (cx_s == 4'b0000)) in_st <= IN_NEUTRAL;
            IN_NEUTRAL: begin
               rxe_q <= 1'b1;
               in_st <= IN_WAIT;
            end
            default: in_st <= IN_WAIT;
         endcase
      end
   end

   assign Rxe = rxe_q;
   assign Cxe = rxe_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         out_st <= OUT_IDLE;
         tx_q   <= '0;
      end else begin
         case (out_st)
            OUT_IDLE: if ((count != '0) && txe_s) begin
               tx_q   <= bin2onehot(head.value);
               out_st <= OUT_DRIVE;
            end
            OUT_DRIVE: if (!txe_s) begin
               tx_q   <= '0;
               out_st <= OUT_RTZ;
            end
            OUT_RTZ: if (txe_s) out_st <= OUT_IDLE;
            default: out_st <= OUT_IDLE;
         endcase
      end
   end

   assign Tx = tx_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push)    mem[wr_ptr] <= push_ent;
      if (clr_dup) mem[rd_ptr].dup <= 1'b0;
   end

   assign LEVEL = count;

endmodule

// File: tb/tb_qdi_1of4_sync_responder.sv
// Directed plus randomized bench for qdi_1of4_sync_responder against a token-queue model.
module tb_qdi_1of4_sync_responder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned SYNC  = 2;
   localparam int          BUD   = 200;
`ifdef QDI_RESPONDER_ERRCHK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] Rx, Cx, Tx;
   logic       Rxe, Cxe, Txe, ERR;
   logic [$clog2(DEPTH):0] LEVEL;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   always #5 CLK = ~CLK;

   qdi_1of4_sync_responder #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .CLK(CLK), .RESET(RESET), .Rx(Rx), .Rxe(Rxe), .Cx(Cx), .Cxe(Cxe),
      .Tx(Tx), .Txe(Txe), .ERR(ERR), .LEVEL(LEVEL));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Reference rules: op0 emits nothing, op1 emits 3-d, op2 emits d twice, op3 emits d.
   task automatic model(input int d, input int c);
      if (c == 1) exp_q.push_back(3 - d);
      else if (c == 2) begin exp_q.push_back(d); exp_q.push_back(d); end
      else if (c == 3) exp_q.push_back(d);
   endtask

   task automatic present(input int d, input int c);
      logic [3:0] one;
      one = 4'b0001;
      Rx = one << d;
      Cx = one << c;
   endtask

   task automatic wait_rxe(input logic v, input string tag);
      int n;
      n = 0;
      while (Rxe !== v && n < BUD) begin tick(1); n++; end
      check(tag, Rxe, v);
      check({tag, "_cxe"}, Cxe, v);
   endtask

   task automatic send(input int d, input int c);
      present(d, c);
      wait_rxe(1'b0, "ack");
      model(d, c);
      Rx = '0; Cx = '0;
      wait_rxe(1'b1, "reen");
   endtask

   task automatic recv(input string tag);
      logic [3:0] one, exp;
      int n;
      one = 4'b0001;
      exp = one << exp_q.pop_front();
      Txe = 1'b1;
      n = 0;
      while (Tx === 4'b0000 && n < BUD) begin tick(1); n++; end
      check(tag, Tx, exp);
      tick(1);
      check({tag, "_hold"}, Tx, exp);
      Txe = 1'b0;
      n = 0;
      while (Tx !== 4'b0000 && n < BUD) begin tick(1); n++; end
      check({tag, "_rtz"}, Tx, 4'b0000);
      Txe = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ack_n, tx_n, d;
      RESET = 1'b0; Rx = '0; Cx = '0; Txe = 1'b1;
      tick(3);
      check("rst_rxe", Rxe, 1'b1);
      check("rst_cxe", Cxe, 1'b1);
      check("rst_tx", Tx, 4'b0000);
      check("rst_err", ERR, 1'b0);
      check("rst_level", LEVEL, 0);
      RESET = 1'b1;
      tick(4);

      // d=3 op=3: acknowledge and output latency measured from the pins
      present(3, 3);
      n = 0; ack_n = -1; tx_n = -1;
      while ((ack_n < 0 || tx_n < 0) && n < BUD) begin
         tick(1); n++;
         if (ack_n < 0 && Rxe === 1'b0) begin
            ack_n = n;
            check("lvl_at_ack", LEVEL, 1);
         end
         if (tx_n < 0 && Tx !== 4'b0000) tx_n = n;
      end
      check("ack_lat", ack_n, SYNC + 1);
      check("tx_lat", tx_n, SYNC + 2);
      check("cxe_eq", Cxe, Rxe);
      model(3, 3);
      Rx = '0; Cx = '0;
      n = 0;
      while (Rxe !== 1'b1 && n < BUD) begin tick(1); n++; end
      check("reen_lat", n, SYNC + 2);
      recv("fwd3");
      tick(5);
      check("fwd3_level", LEVEL, 0);

      send(1, 1);
      recv("inv1");
      tick(5);
      send(2, 0);
      tick(10);
      check("drop_tx", Tx, 4'b0000);
      check("drop_level", LEVEL, 0);

      send(0, 2);
      recv("dup_a");
      tick(5);
      check("dup_level", LEVEL, 1);
      check("dup_again", Tx, 4'b0001);
      recv("dup_b");
      tick(5);
      check("dup_done", LEVEL, 0);

      for (int i = 0; i < 12; i++) begin
         send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         while (exp_q.size() > 0) recv("rand");
         tick(5);
         check("rand_level", LEVEL, 0);
         check("rand_tx", Tx, 4'b0000);
      end

      // Fill with Txe held low, then one more token that must wait for space
      Txe = 1'b0;
      tick(4);
      for (int i = 0; i < int'(DEPTH); i++) send(int'($urandom_range(0, 3)), 3);
      check("full_level", LEVEL, DEPTH);
      d = int'($urandom_range(0, 3));
      present(d, 3);
      tick(20);
      check("full_noack", Rxe, 1'b1);
      check("full_hold", LEVEL, DEPTH);
      recv("wrap0");
      wait_rxe(1'b0, "late_ack");
      model(d, 3);
      Rx = '0; Cx = '0;
      wait_rxe(1'b1, "late_reen");
      while (exp_q.size() > 0) recv("wrap");
      tick(5);
      check("wrap_level", LEVEL, 0);

      Rx = 4'b0011; Cx = 4'b0001;
      tick(10);
      check("mh_rxe", Rxe, 1'b1);
      check("mh_level", LEVEL, 0);
      check("mh_err", ERR, ERR_EN);
      Rx = '0; Cx = '0;
      tick(6);
      check("mh_sticky", ERR, ERR_EN);
      send(2, 3);
      recv("after_mh");
      check("mh_sticky2", ERR, ERR_EN);
      tick(5);

      send(1, 3);
      n = 0;
      while (Tx === 4'b0000 && n < BUD) begin tick(1); n++; end
      check("pre_rst_tx", Tx, 4'b0010);
      RESET = 1'b0;
      #1;
      check("mid_rst_tx", Tx, 4'b0000);
      check("mid_rst_rxe", Rxe, 1'b1);
      check("mid_rst_level", LEVEL, 0);
      check("mid_rst_err", ERR, 1'b0);
      exp_q.delete();
      tick(3);
      RESET = 1'b1;
      tick(6);
      check("post_rst_tx", Tx, 4'b0000);
      check("post_rst_level", LEVEL, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
